// File: rtl/axis_packetizer.sv
// axis_packetizer: chops AXIS messages into NoC packets of at most MAX_PKT_BEATS
// beats, freezing tid/tdest for the whole message, through a 2-entry
// registered skid buffer.
// Optional feature macro: AXIS_PACKETIZER_STATS_EN (packet/message counters).
module axis_packetizer #(
  parameter int unsigned TID_WIDTH     = 2,
  parameter int unsigned TDEST_WIDTH   = 4,
  parameter int unsigned TDATA_WIDTH   = 512,
  parameter int unsigned MAX_PKT_BEATS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic [TID_WIDTH-1:0]   s_axis_tid,
  input  logic [TDEST_WIDTH-1:0] s_axis_tdest,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic [TID_WIDTH-1:0]   m_axis_tid,
  output logic [TDEST_WIDTH-1:0] m_axis_tdest,
`ifdef AXIS_PACKETIZER_STATS_EN
  input  logic                   stat_clear,
  output logic [31:0]            stat_pkt_count,
  output logic [31:0]            stat_msg_count,
`endif
  output logic                   err_dest_change
);

  localparam int unsigned CNT_W = $clog2(MAX_PKT_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_BEATS - 1);

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] data;
    logic                   last;
    logic [TID_WIDTH-1:0]   id;
    logic [TDEST_WIDTH-1:0] dest;
`ifdef AXIS_PACKETIZER_STATS_EN
    logic                   msg_end;
`endif
  } beat_t;

  typedef enum logic {ST_IDLE, ST_MID} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TID_WIDTH-1:0]   lat_id_q, lat_id_d;
  logic [TDEST_WIDTH-1:0] lat_dest_q, lat_dest_d;
  logic                   err_q, err_d;
  logic [1:0]             occ_q, occ_d;
  logic                   rdy_q, rdy_d;
  logic                   vld_q, vld_d;
  beat_t                  head_q, head_d;
  beat_t                  tail_q, tail_d;
  beat_t                  in_beat;
  logic                   push, pop;
`ifdef AXIS_PACKETIZER_STATS_EN
  logic [31:0]            pkt_cnt_q, pkt_cnt_d;
  logic [31:0]            msg_cnt_q, msg_cnt_d;
`endif

  // Next-state: message FSM, packet beat counter, skid buffer, sticky error
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_id_d   = lat_id_q;
    lat_dest_d = lat_dest_q;
    err_d      = err_q;
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    push       = s_axis_tvalid && rdy_q;
    pop        = vld_q && m_axis_tready;

    in_beat.data = s_axis_tdata;
    in_beat.last = s_axis_tlast || (cnt_q == CNT_LAST);
    in_beat.id   = (state_q == ST_IDLE) ? s_axis_tid   : lat_id_q;
    in_beat.dest = (state_q == ST_IDLE) ? s_axis_tdest : lat_dest_q;
`ifdef AXIS_PACKETIZER_STATS_EN
    in_beat.msg_end = s_axis_tlast;
`endif

    if (push) begin
      cnt_d = in_beat.last ? '0 : CNT_W'(cnt_q + 1'b1);
      if (state_q == ST_IDLE) begin
        lat_id_d   = s_axis_tid;
        lat_dest_d = s_axis_tdest;
        if (!s_axis_tlast) state_d = ST_MID;
      end else begin
        if ({s_axis_tid, s_axis_tdest} != {lat_id_q, lat_dest_q}) err_d = 1'b1;
        if (s_axis_tlast) state_d = ST_IDLE;
      end
    end

    // head drives m_axis directly; tail only fills when head is stalled
    case (occ_q)
      2'd0: begin
        if (push) begin
          head_d = in_beat;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = in_beat;
        end else if (push) begin
          tail_d = in_beat;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          occ_d  = 2'd1;
        end
      end
    endcase

    vld_d = (occ_d != 2'd0);
    rdy_d = (occ_d < 2'd2);
  end

`ifdef AXIS_PACKETIZER_STATS_EN
  // Saturating statistics; clear takes priority over an increment
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    msg_cnt_d = msg_cnt_q;
    if (stat_clear) begin
      pkt_cnt_d = '0;
      msg_cnt_d = '0;
    end else if (pop) begin
      if (head_q.last && (pkt_cnt_q != 32'hFFFF_FFFF))    pkt_cnt_d = pkt_cnt_q + 32'd1;
      if (head_q.msg_end && (msg_cnt_q != 32'hFFFF_FFFF)) msg_cnt_d = msg_cnt_q + 32'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
      msg_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      msg_cnt_q <= msg_cnt_d;
    end
  end

  assign stat_pkt_count = pkt_cnt_q;
  assign stat_msg_count = msg_cnt_q;
`endif

  // State registers; reset drops any buffered beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      lat_id_q   <= '0;
      lat_dest_q <= '0;
      err_q      <= 1'b0;
      occ_q      <= 2'd0;
      rdy_q      <= 1'b0;
      vld_q      <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_id_q   <= lat_id_d;
      lat_dest_q <= lat_dest_d;
      err_q      <= err_d;
      occ_q      <= occ_d;
      rdy_q      <= rdy_d;
      vld_q      <= vld_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign s_axis_tready   = rdy_q;
  assign m_axis_tvalid   = vld_q;
  assign m_axis_tdata    = head_q.data;
  assign m_axis_tlast    = head_q.last;
  assign m_axis_tid      = head_q.id;
  assign m_axis_tdest    = head_q.dest;
  assign err_dest_change = err_q;

endmodule
